codec_irq_bridge: RTL and testbench

- Multi-channel interrupt handshake bridge for the codec cluster. Generalises the single MCU int/ack pair into NumChannels independent channels.
- Each channel counts incoming event pulses and forwards each one to the next agent over a four-phase int/ack handshake.
- Also produces the global pintreq/pintbus summary for the host.
- Sits between codec event sources (decoder cores, MCU) and the neighbouring MCU / host interrupt controller.

---
 rtl/codec_irq_bridge.sv | 143 ++++++++++++++
 tb/tb_codec_irq_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_irq_bridge.sv
// Multi-channel four-phase int/ack interrupt bridge with per-channel pending-event counters.
// Ack-timeout detection is built only when CODEC_IRQ_BRIDGE_TIMEOUT_EN is defined.
module codec_irq_bridge #(
    parameter int NumChannels  = 4,
    parameter int CntWidth     = 4,
    parameter int TimeoutWidth = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NumChannels-1:0]          i_evt,
    input  logic [NumChannels-1:0]          i_ack,
    input  logic [NumChannels-1:0]          i_clr,
    input  logic [TimeoutWidth-1:0]         i_timeout_cycles,
    output logic [NumChannels-1:0]          o_int,
    output logic [NumChannels*CntWidth-1:0] o_pending,
    output logic [NumChannels-1:0]          o_ovf,
    output logic [NumChannels-1:0]          o_timeout,
    output logic                            o_pintreq,
    output logic [NumChannels-1:0]          o_pintbus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    state_e                 state_q [NumChannels];
    state_e                 state_d [NumChannels];
    logic [CntWidth-1:0]    cnt_q   [NumChannels];
    logic [CntWidth-1:0]    cnt_d   [NumChannels];
    logic [NumChannels-1:0] ovf_q, ovf_d;
    logic [NumChannels-1:0] bus_q, bus_d;
    logic                   pintreq_q;

    always_comb begin
        logic inc_c;
        logic dec_c;
        for (int c = 0; c < NumChannels; c++) begin
            // An event arriving at saturation is still absorbed when an ack frees a slot.
            dec_c      = (state_q[c] == REQ) && i_ack[c];
            inc_c      = i_evt[c] && ((cnt_q[c] != CntMax) || dec_c);
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            ovf_d[c]   = ovf_q[c];
            if (i_clr[c]) begin
                state_d[c] = IDLE;
                cnt_d[c]   = '0;
                ovf_d[c]   = 1'b0;
            end else begin
                if (i_evt[c] && !inc_c) ovf_d[c] = 1'b1;
                if (inc_c && !dec_c)      cnt_d[c] = cnt_q[c] + CntOne;
                else if (dec_c && !inc_c) cnt_d[c] = cnt_q[c] - CntOne;
                case (state_q[c])
                    IDLE:     if ((cnt_q[c] != '0) && !i_ack[c]) state_d[c] = REQ;
                    REQ:      if (i_ack[c]) state_d[c] = WAIT_LOW;
                    WAIT_LOW: if (!i_ack[c]) state_d[c] = IDLE;
                    default:  state_d[c] = IDLE;
                endcase
            end
            bus_d[c] = (cnt_d[c] != '0) || (state_d[c] == REQ);
        end
    end

    // NOTE: every per-channel register array is small and must start defined, so all of it is reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NumChannels; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
            end
            ovf_q     <= '0;
            bus_q     <= '0;
            pintreq_q <= 1'b0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            ovf_q     <= ovf_d;
            bus_q     <= bus_d;
            pintreq_q <= |bus_d;
        end
    end

    always_comb begin
        o_int     = '0;
        o_pending = '0;
        for (int c = 0; c < NumChannels; c++) begin
            o_int[c]                         = (state_q[c] == REQ);
            o_pending[c*CntWidth +: CntWidth] = cnt_q[c];
        end
    end

    assign o_ovf     = ovf_q;
    assign o_pintbus = bus_q;
    assign o_pintreq = pintreq_q;

`ifdef CODEC_IRQ_BRIDGE_TIMEOUT_EN
    logic [TimeoutWidth-1:0] tcnt_q [NumChannels];
    logic [TimeoutWidth-1:0] tcnt_d [NumChannels];
    logic [NumChannels-1:0]  to_q, to_d;

    // The wait counter parks at the threshold; the request itself stays up until acked.
    always_comb begin
        for (int c = 0; c < NumChannels; c++) begin
            tcnt_d[c] = tcnt_q[c];
            to_d[c]   = to_q[c];
            if (i_clr[c]) begin
                tcnt_d[c] = '0;
                to_d[c]   = 1'b0;
            end else if ((state_q[c] == REQ) && !i_ack[c]) begin
                if (i_timeout_cycles != '0) begin
                    if (tcnt_q[c] == i_timeout_cycles) to_d[c] = 1'b1;
                    else tcnt_d[c] = tcnt_q[c] + TimeoutWidth'(1);
                end
            end else begin
                tcnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NumChannels; c++) tcnt_q[c] <= '0;
            to_q <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) tcnt_q[c] <= tcnt_d[c];
            to_q <= to_d;
        end
    end

    assign o_timeout = to_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^i_timeout_cycles;
    assign o_timeout             = '0;
`endif

endmodule

// File: tb/tb_codec_irq_bridge.sv
// Scoreboard bench for codec_irq_bridge: per-cycle expectations are queued as stimulus is
// driven and compared against the outputs on the falling edge of the matching cycle.
module tb_codec_irq_bridge;

    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int TW  = 16;
`ifdef CODEC_IRQ_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    evt, ack, clr;
    logic [TW-1:0]     thr;
    logic [NCH-1:0]    o_int, o_ovf, o_timeout, o_pintbus;
    logic [NCH*CW-1:0] o_pending;
    logic              o_pintreq;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cy;
        int         ch;
        logic [3:0] pend;
        logic       intr;
        logic       ovf;
        logic       to;
        logic       bus;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    codec_irq_bridge #(
        .NumChannels (NCH),
        .CntWidth    (CW),
        .TimeoutWidth(TW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_evt           (evt),
        .i_ack           (ack),
        .i_clr           (clr),
        .i_timeout_cycles(thr),
        .o_int           (o_int),
        .o_pending       (o_pending),
        .o_ovf           (o_ovf),
        .o_timeout       (o_timeout),
        .o_pintreq       (o_pintreq),
        .o_pintbus       (o_pintbus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    function automatic void push(input int cy, input string nm, input int ch, input int p,
                                 input bit i, input bit o, input bit t, input bit b);
        exp_t e;
        e.cy   = cy;
        e.ch   = ch;
        e.pend = 4'(p);
        e.intr = i;
        e.ovf  = o;
        e.to   = t;
        e.bus  = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endfunction

    task automatic run_monitor();
        exp_t       e;
        string      nm;
        logic [3:0] act_p;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cy <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (e.cy != cyc) begin
                    errors++;
                    $display("FAIL %s ch%0d: expectation for cycle %0d compared late at cycle %0d",
                             nm, e.ch, e.cy, cyc);
                end else begin
                    act_p = o_pending[e.ch*CW +: CW];
                    if ({act_p, o_int[e.ch], o_ovf[e.ch], o_timeout[e.ch], o_pintbus[e.ch]} !==
                        {e.pend, e.intr, e.ovf, e.to, e.bus}) begin
                        errors++;
                        $display("FAIL %s ch%0d cyc%0d: got pend=%0d int=%b ovf=%b to=%b bus=%b, want pend=%0d int=%b ovf=%b to=%b bus=%b",
                                 nm, e.ch, cyc, act_p, o_int[e.ch], o_ovf[e.ch], o_timeout[e.ch],
                                 o_pintbus[e.ch], e.pend, e.intr, e.ovf, e.to, e.bus);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        evt = '0;
        ack = '0;
        clr = '0;
        thr = '0;
        repeat (3) tick();
        checks++;
        if ({o_int, o_pending, o_ovf, o_timeout, o_pintreq, o_pintbus} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got int=%h pend=%h ovf=%h to=%h req=%b bus=%h, want all 0",
                     o_int, o_pending, o_ovf, o_timeout, o_pintreq, o_pintbus);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({o_int, o_pending, o_pintreq, o_pintbus} !== '0) begin
            errors++;
            $display("FAIL reset_release: got int=%h pend=%h req=%b bus=%h, want all 0",
                     o_int, o_pending, o_pintreq, o_pintbus);
        end
    endtask

    task automatic test_single_event();
        int t;
        t = cyc + 2;
        wait_cyc(t);
        evt[0] = 1'b1;
        push(t + 1, "single_pend", 0, 1, 0, 0, 0, 1);
        push(t + 2, "single_int",  0, 1, 1, 0, 0, 1);
        push(t + 3, "single_hold", 0, 1, 1, 0, 0, 1);
        push(t + 4, "single_hold", 0, 1, 1, 0, 0, 1);
        tick();
        evt[0] = 1'b0;
        wait_cyc(t + 5);
        ack[0] = 1'b1;
        push(t + 5, "single_ackcyc", 0, 1, 1, 0, 0, 1);
        push(t + 6, "single_acked",  0, 0, 0, 0, 0, 0);
        push(t + 7, "single_wait",   0, 0, 0, 0, 0, 0);
        wait_cyc(t + 8);
        ack[0] = 1'b0;
        push(t + 8, "single_acklow", 0, 0, 0, 0, 0, 0);
        push(t + 9, "single_idle",   0, 0, 0, 0, 0, 0);
        wait_cyc(t + 9);
        checks++;
        if (o_pintreq !== 1'b0) begin
            errors++;
            $display("FAIL single_pintreq: got %b, want 0", o_pintreq);
        end
    endtask

    task automatic test_saturate();
        int t;
        t = cyc + 2;
        wait_cyc(t);
        evt[1] = 1'b1;
        for (int k = 1; k <= 21; k++)
            push(t + k, "sat_count", 1, (k >= 15) ? 15 : k, k >= 2, k >= 16, 0, 1);
        wait_cyc(t + 10);
        checks++;
        if (o_pintreq !== 1'b1) begin
            errors++;
            $display("FAIL sat_pintreq: got %b, want 1", o_pintreq);
        end
        wait_cyc(t + 20);
        evt[1] = 1'b0;
        push(t + 25, "sat_ovf_sticky", 1, 15, 1, 1, 0, 1);
        push(t + 26, "sat_ovf_sticky", 1, 15, 1, 1, 0, 1);
        wait_cyc(t + 26);
        clr[1] = 1'b1;
        push(t + 27, "sat_clr", 1, 0, 0, 0, 0, 0);
        push(t + 28, "sat_clr_after", 1, 0, 0, 0, 0, 0);
        tick();
        clr[1] = 1'b0;
        wait_cyc(t + 29);
    endtask

    task automatic test_sat_with_ack();
        int t;
        t = cyc + 2;
        wait_cyc(t);
        evt[2] = 1'b1;
        wait_cyc(t + 15);
        evt[2] = 1'b0;
        push(t + 15, "satack_full", 2, 15, 1, 0, 0, 1);
        wait_cyc(t + 16);
        evt[2] = 1'b1;
        ack[2] = 1'b1;
        push(t + 16, "satack_cyc",   2, 15, 1, 0, 0, 1);
        push(t + 17, "satack_hold",  2, 15, 0, 0, 0, 1);
        push(t + 18, "satack_idle",  2, 15, 0, 0, 0, 1);
        push(t + 19, "satack_rereq", 2, 15, 1, 0, 0, 1);
        tick();
        evt[2] = 1'b0;
        ack[2] = 1'b0;
        wait_cyc(t + 20);
        clr[2] = 1'b1;
        push(t + 21, "satack_clr", 2, 0, 0, 0, 0, 0);
        tick();
        clr[2] = 1'b0;
        wait_cyc(t + 22);
    endtask

    task automatic test_timeout();
        int t;
        t = cyc + 2;
        wait_cyc(t);
        thr    = 16'd8;
        evt[3] = 1'b1;
        for (int k = 1; k <= 14; k++)
            push(t + k, "to_wait", 3, 1, k >= 2, 0, TO_EN && (k >= 11), 1);
        tick();
        evt[3] = 1'b0;
        wait_cyc(t + 15);
        ack[3] = 1'b1;
        push(t + 15, "to_ackcyc", 3, 1, 1, 0, TO_EN, 1);
        push(t + 16, "to_acked",  3, 0, 0, 0, TO_EN, 0);
        wait_cyc(t + 17);
        ack[3] = 1'b0;
        push(t + 17, "to_sticky", 3, 0, 0, 0, TO_EN, 0);
        push(t + 18, "to_sticky", 3, 0, 0, 0, TO_EN, 0);
        wait_cyc(t + 19);
        clr[3] = 1'b1;
        push(t + 20, "to_clr", 3, 0, 0, 0, 0, 0);
        tick();
        clr[3] = 1'b0;
        thr    = '0;
        wait_cyc(t + 21);
    endtask

    task automatic test_clr_mid();
        int t;
        int s;
        t = cyc + 2;
        wait_cyc(t);
        evt[0] = 1'b1;
        wait_cyc(t + 3);
        evt[0] = 1'b0;
        push(t + 3, "clr_req3", 0, 3, 1, 0, 0, 1);
        wait_cyc(t + 4);
        clr[0] = 1'b1;
        evt[0] = 1'b1;
        push(t + 4, "clr_req3",  0, 3, 1, 0, 0, 1);
        push(t + 5, "clr_flush", 0, 0, 0, 0, 0, 0);
        push(t + 6, "clr_quiet", 0, 0, 0, 0, 0, 0);
        tick();
        clr[0] = 1'b0;
        evt[0] = 1'b0;

        s = cyc + 2;
        wait_cyc(s);
        evt[0] = 1'b1;
        wait_cyc(s + 2);
        evt[0] = 1'b0;
        push(s + 2, "clrack_req", 0, 2, 1, 0, 0, 1);
        wait_cyc(s + 3);
        ack[0] = 1'b1;
        clr[0] = 1'b1;
        push(s + 3, "clrack_req",   0, 2, 1, 0, 0, 1);
        push(s + 4, "clrack_flush", 0, 0, 0, 0, 0, 0);
        tick();
        clr[0] = 1'b0;
        evt[0] = 1'b1;
        push(s + 5, "clrack_blocked", 0, 1, 0, 0, 0, 1);
        push(s + 6, "clrack_blocked", 0, 1, 0, 0, 0, 1);
        push(s + 7, "clrack_blocked", 0, 1, 0, 0, 0, 1);
        tick();
        evt[0] = 1'b0;
        wait_cyc(s + 7);
        ack[0] = 1'b0;
        push(s + 8, "clrack_req", 0, 1, 1, 0, 0, 1);
        wait_cyc(s + 9);
        ack[0] = 1'b1;
        push(s + 9,  "clrack_ackcyc", 0, 1, 1, 0, 0, 1);
        push(s + 10, "clrack_done",   0, 0, 0, 0, 0, 0);
        tick();
        ack[0] = 1'b0;
        push(s + 11, "clrack_idle", 0, 0, 0, 0, 0, 0);
        wait_cyc(s + 12);
    endtask

    task automatic test_reset_mid();
        int t;
        t = cyc + 2;
        wait_cyc(t);
        evt = '1;
        wait_cyc(t + 2);
        evt = '0;
        wait_cyc(t + 3);
        ack = '1;
        for (int c = 0; c < NCH; c++) push(t + 4, "rstmid_wait", c, 1, 0, 0, 0, 1);
        wait_cyc(t + 4);
        rst = 1'b1;
        for (int k = 5; k <= 10; k++)
            for (int c = 0; c < NCH; c++) push(t + k, "rstmid_zero", c, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        checks++;
        if ({o_int, o_pending, o_ovf, o_timeout, o_pintreq, o_pintbus} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got int=%h pend=%h ovf=%h to=%h req=%b bus=%h, want all 0",
                     o_int, o_pending, o_ovf, o_timeout, o_pintreq, o_pintbus);
        end
        wait_cyc(t + 9);
        ack = '0;
        wait_cyc(t + 11);
        evt[0] = 1'b1;
        push(t + 12, "rstmid_newevt", 0, 1, 0, 0, 0, 1);
        push(t + 13, "rstmid_newint", 0, 1, 1, 0, 0, 1);
        tick();
        evt[0] = 1'b0;
        wait_cyc(t + 14);
        ack[0] = 1'b1;
        push(t + 15, "rstmid_done", 0, 0, 0, 0, 0, 0);
        tick();
        ack[0] = 1'b0;
        wait_cyc(t + 16);
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_single_event();
        test_saturate();
        test_sat_with_ack();
        test_timeout();
        test_clr_mid();
        test_reset_mid();
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
